program_loader: RTL and testbench
=================================

# program_loader

Boot-time program loader for the multi-cycle CPU. It takes a byte stream from the host link (UART receiver or testbench), assembles little-endian 32-bit instruction words, and drives the sequential write port of the instruction memory. The instruction memory sits directly downstream. The loader keeps the CPU core held until a complete program image is in memory.

## Interface

Parameters:
- width, 32: instruction word width; must be a multiple of 8.
- DEPTH, 64: maximum number of words the instruction memory write counter can address.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  reset, synchronous and active-low.
- start  in  1  one-cycle request to begin a new load.
- byte_valid  in  1  host byte present.
- byte_data  in  8  host byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_rst  out  1  one-cycle pulse that clears the instruction memory write counter (active-high, synchronous on the memory side).
- mem_write  out  1  one-cycle write strobe to the instruction memory.
- mem_data  out  width  word to be written; valid while mem_write=1.
- words_loaded  out  8  number of words written in the current load.
- cpu_hold  out  1  holds the CPU core in reset while high.
- done  out  1  the load completed successfully.
- error  out  1  the header word count exceeded DEPTH.

## Operation

- A byte is transferred only on a cycle where byte_valid=1 and byte_ready=1. byte_ready depends on state only, never on byte_valid.
- The image format is a header byte N (word count, 0..255), followed by N×(width/8) bytes. Each word arrives least-significant byte first.
- States and transitions:
  - IDLE: byte_ready=0, cpu_hold=1. On start, go to CLEAR.
  - CLEAR: for exactly one cycle, mem_rst=1, words_loaded←0, byte index←0. Then go to COUNT.
  - COUNT: byte_ready=1. On a handshake, latch N.
    - N=0: go to DONE.
    - N>DEPTH: go to ERR.
    - Otherwise: go to DATA.
  - DATA: byte_ready=1. Each handshake shifts the byte into the assembly register at position (byte index × 8).
    - On the last byte of a word, mem_data←assembled word and mem_write is pulsed on the next cycle. words_loaded increments on that same cycle.
    - When words_loaded reaches N (on the write cycle of the last word), go to DONE.
  - DONE: byte_ready=0, done=1, cpu_hold=0. On start, go to CLEAR and clear done.
  - ERR: byte_ready=0, error=1, cpu_hold=1, no writes. On start, go to CLEAR and clear error.
- start is ignored in CLEAR, COUNT and DATA.
- Bytes offered while byte_ready=0 are not consumed and have no effect.
- The byte index wraps width/8−1 → 0. words_loaded never exceeds N.
- mem_data holds its last value between strobes.

## Timing

- Reset (rst=0 at a clock edge) gives:
  - state IDLE
  - byte_ready=0, mem_rst=0, mem_write=0
  - mem_data=0, words_loaded=0
  - done=0, error=0, cpu_hold=1
  - assembly register and byte index = 0
- Reset mid-load aborts immediately with the same values. No partial write strobe is emitted.
- A start pulse produces mem_rst=1 one cycle later and byte_ready=1 two cycles later.
- Write latency is 1 cycle: mem_write=1 on the cycle after the handshake of a word's final byte, for exactly one cycle.
- Full-rate streaming: byte_ready stays high during the mem_write cycle. A byte accepted in that cycle goes into the next word without loss.
- done=1 and cpu_hold=0 appear on the cycle after the final mem_write. byte_ready is 0 from that same cycle.
- A header with N=0 gives done=1 one cycle after the header handshake.
- A header with N>DEPTH gives error=1 one cycle after the header handshake.
- Throughput is one byte per cycle. The minimum full load is 2 + 1 + N×(width/8) + 1 cycles from start to done.

## Test plan

- Reset, then start, then N=2 and bytes 13 00 00 00 93 00 10 00 sent back-to-back. Expect:
  - one mem_rst pulse
  - mem_write pulses carrying 0x00000013 and then 0x00100093
  - words_loaded=2
  - done=1 and cpu_hold=0 one cycle after the second strobe
- The same image with byte_valid toggling every other cycle gives identical memory contents and strobe count, with each strobe one cycle after the 4th byte of its word.
- N=0 gives done=1 with no mem_write. N=65 with DEPTH=64 gives error=1, cpu_hold=1, no mem_write, and byte_ready=0 afterwards.
- Assert rst=0 after 6 data bytes of an N=3 load. Expect all outputs at reset values the next cycle and no strobe. A fresh load of N=1 (EF BE AD DE) then writes 0xDEADBEEF.
- start pulsed during DATA is ignored and the load completes normally. start in DONE triggers mem_rst and a new load, with done=0 from the CLEAR cycle.
- A load of N=DEPTH=64 words produces exactly 64 strobes and words_loaded=64 before done.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: assembles a host byte stream into instruction words and writes them to memory while holding the CPU.
module program_loader #(
    parameter int width = 32,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             mem_rst,
    output logic             mem_write,
    output logic [width-1:0] mem_data,
    output logic [7:0]       words_loaded,
    output logic             cpu_hold,
    output logic             done,
    output logic             error
);
    localparam int BYTES = width / 8;
    localparam int IW = BYTES > 1 ? $clog2(BYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(BYTES - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, COUNT, DATA, DONE, ERR} state_t;
    state_t state, nxt;

    logic             hs;
    logic [7:0]       n;
    logic [IW-1:0]    idx;
    logic [width-1:0] shreg, word;

    assign hs = byte_valid && byte_ready;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE, ERR: nxt = start ? CLEAR : state;
            CLEAR:           nxt = COUNT;
            COUNT:           nxt = !hs ? COUNT : byte_data == 8'd0 ? DONE : 32'(byte_data) > DEPTH ? ERR : DATA;
            DATA:            nxt = (mem_write && words_loaded == n) ? DONE : DATA;
            default:         nxt = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = state == COUNT || state == DATA;
        mem_rst    = state == CLEAR;
        done       = state == DONE;
        error      = state == ERR;
        cpu_hold   = state != DONE;
    end

    // word as it will look once the current byte lands at its lane
    always_comb begin
        word = shreg;
        word[idx*8 +: 8] = byte_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_write    <= 1'b0;
            mem_data     <= '0;
            words_loaded <= '0;
            n            <= '0;
            idx          <= '0;
            shreg        <= '0;
        end else begin
            mem_write <= hs && state == DATA && idx == LAST;
            if (state == CLEAR) begin
                words_loaded <= '0;
                idx          <= '0;
                shreg        <= '0;
            end
            if (hs && state == COUNT) n <= byte_data;
            if (hs && state == DATA) begin
                shreg <= word;
                idx   <= idx == LAST ? '0 : idx + IW'(1);
                if (idx == LAST) begin
                    mem_data     <= word;
                    words_loaded <= words_loaded + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed checks of the loader's handshake, write strobes, status flags and reset behaviour.
module tb_program_loader;
    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready, mem_rst, mem_write, cpu_hold, done, error;
    logic [31:0] mem_data;
    logic [7:0]  words_loaded;

    program_loader #(.width(32), .DEPTH(64)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .mem_rst(mem_rst), .mem_write(mem_write), .mem_data(mem_data),
        .words_loaded(words_loaded), .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int strobes = 0, rsts = 0, lat_bad = 0;
    int b0, w0, r0;
    logic prev_hs = 1'b0;
    logic [31:0] wq[$];
    logic [7:0] img[$];

    // every strobe must follow a handshake cycle directly
    always @(negedge clk) begin
        if (mem_write) begin
            strobes++;
            wq.push_back(mem_data);
            if (!prev_hs) lat_bad++;
        end
        if (mem_rst) rsts++;
        prev_hs = byte_valid && byte_ready;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task tick;
        @(posedge clk);
        #1;
    endtask

    task pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task send(input logic [7:0] b, input bit gap);
        int g;
        g = 0;
        byte_valid = 1'b1;
        byte_data = b;
        while (!byte_ready && g < 20) begin
            tick;
            g++;
        end
        if (!byte_ready) check("ready_timeout", 32'd0, 32'd1);
        tick;
        byte_valid = 1'b0;
        if (gap) tick;
    endtask

    task send_img(input bit gap);
        for (int i = 0; i < img.size(); i++) send(img[i], gap && i != img.size() - 1);
    endtask

    task reset_vals(input string tag);
        check({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_mem_rst"}, 32'(mem_rst), 32'd0);
        check({tag, "_write"}, 32'(mem_write), 32'd0);
        check({tag, "_data"}, mem_data, 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    endtask

    function automatic logic [31:0] wq_at(input int i);
        return (wq.size() > i) ? wq[i] : 32'hxxxxxxxx;
    endfunction

    initial begin
        tick;
        tick;
        reset_vals("reset");
        rst = 1'b1;
        tick;
        // basic back-to-back load of two words
        r0 = rsts;
        pulse_start;
        check("clear_mem_rst", 32'(mem_rst), 32'd1);
        check("clear_ready", 32'(byte_ready), 32'd0);
        tick;
        check("count_ready", 32'(byte_ready), 32'd1);
        b0 = strobes;
        w0 = wq.size();
        img = '{8'd2, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_img(1'b0);
        check("t1_write", 32'(mem_write), 32'd1);
        check("t1_data", mem_data, 32'h00100093);
        check("t1_words", 32'(words_loaded), 32'd2);
        check("t1_done_early", 32'(done), 32'd0);
        tick;
        check("t1_done", 32'(done), 32'd1);
        check("t1_hold", 32'(cpu_hold), 32'd0);
        check("t1_ready", 32'(byte_ready), 32'd0);
        check("t1_write_off", 32'(mem_write), 32'd0);
        check("t1_strobes", 32'(strobes - b0), 32'd2);
        check("t1_w0", wq_at(w0), 32'h00000013);
        check("t1_w1", wq_at(w0 + 1), 32'h00100093);
        check("t1_mem_rst_cnt", 32'(rsts - r0), 32'd1);
        // restart from DONE with throttled bytes
        r0 = rsts;
        pulse_start;
        check("t2_mem_rst", 32'(mem_rst), 32'd1);
        check("t2_done_clr", 32'(done), 32'd0);
        tick;
        b0 = strobes;
        w0 = wq.size();
        send_img(1'b1);
        check("t2_write", 32'(mem_write), 32'd1);
        check("t2_data", mem_data, 32'h00100093);
        tick;
        check("t2_done", 32'(done), 32'd1);
        check("t2_strobes", 32'(strobes - b0), 32'd2);
        check("t2_w0", wq_at(w0), 32'h00000013);
        check("t2_w1", wq_at(w0 + 1), 32'h00100093);
        check("t2_latency", 32'(lat_bad), 32'd0);
        check("t2_mem_rst_cnt", 32'(rsts - r0), 32'd1);
        // empty image
        pulse_start;
        tick;
        b0 = strobes;
        img = '{8'd0};
        send_img(1'b0);
        check("n0_done", 32'(done), 32'd1);
        check("n0_words", 32'(words_loaded), 32'd0);
        tick;
        check("n0_strobes", 32'(strobes - b0), 32'd0);
        // oversize header
        pulse_start;
        tick;
        img = '{8'd65};
        send_img(1'b0);
        check("n65_error", 32'(error), 32'd1);
        check("n65_hold", 32'(cpu_hold), 32'd1);
        check("n65_ready", 32'(byte_ready), 32'd0);
        check("n65_done", 32'(done), 32'd0);
        byte_valid = 1'b1;
        byte_data = 8'hAA;
        repeat (3) tick;
        byte_valid = 1'b0;
        check("n65_ready_later", 32'(byte_ready), 32'd0);
        check("n65_error_later", 32'(error), 32'd1);
        check("n65_strobes", 32'(strobes - b0), 32'd0);
        // reset in the middle of the second word
        pulse_start;
        check("err_clr", 32'(error), 32'd0);
        check("err_mem_rst", 32'(mem_rst), 32'd1);
        tick;
        b0 = strobes;
        w0 = wq.size();
        img = '{8'd3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_img(1'b0);
        rst = 1'b0;
        tick;
        reset_vals("abort");
        tick;
        check("abort_strobes", 32'(strobes - b0), 32'd1);
        check("abort_w0", wq_at(w0), 32'h04030201);
        rst = 1'b1;
        tick;
        pulse_start;
        tick;
        img = '{8'd1, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_img(1'b0);
        check("fresh_write", 32'(mem_write), 32'd1);
        check("fresh_data", mem_data, 32'hDEADBEEF);
        tick;
        check("fresh_done", 32'(done), 32'd1);
        // start during DATA is ignored
        pulse_start;
        tick;
        r0 = rsts;
        img = '{8'd1, 8'h44, 8'h33};
        send_img(1'b0);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("ign_mem_rst", 32'(mem_rst), 32'd0);
        check("ign_ready", 32'(byte_ready), 32'd1);
        img = '{8'h22, 8'h11};
        send_img(1'b0);
        check("ign_data", mem_data, 32'h11223344);
        tick;
        check("ign_done", 32'(done), 32'd1);
        check("ign_mem_rst_cnt", 32'(rsts - r0), 32'd0);
        // full-depth image
        pulse_start;
        tick;
        b0 = strobes;
        img = '{8'd64};
        for (int i = 0; i < 64; i++) begin
            img.push_back(8'(i));
            img.push_back(8'h00);
            img.push_back(8'h00);
            img.push_back(8'h00);
        end
        send_img(1'b0);
        check("full_words", 32'(words_loaded), 32'd64);
        check("full_data", mem_data, 32'd63);
        check("full_done_early", 32'(done), 32'd0);
        tick;
        check("full_done", 32'(done), 32'd1);
        check("full_strobes", 32'(strobes - b0), 32'd64);
        check("final_latency", 32'(lat_bad), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
